alarm_dispatcher: RTL
=====================

# alarm_dispatcher

Consumer of the master controller's `alarms` and `occupants_in` outputs. Turns alarm rising edges into prioritised alert messages for the remote notification panel over a valid/ready link, waits for an end-to-end acknowledge, and retries on timeout. Also drives the local buzzer. Sits between `master` and the panel transceiver.

## Interface
Parameters:
- ACK_TIMEOUT, 255: cycles to wait for `msg_ack` after a send handshake.
- MAX_RETRY, 3: resends allowed after the first send.
- HOLDOFF_CYCLES, 16: idle gap enforced after each completed or failed message.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-low.
- alarms  in  3  {fire, intrusion, rain} from `master`. Bit 2 is fire, bit 0 is rain.
- occupants_in  in  8  occupant count from `master`.
- msg_valid  out  1  message offered to the panel.
- msg_ready  in  1  panel accepts the message.
- msg_code  out  2  1 = fire, 2 = intrusion, 3 = rain; 0 when idle.
- msg_occupants  out  8  occupant snapshot taken when the message is selected.
- msg_ack  in  1  single-cycle delivery acknowledge from the panel.
- pending  out  3  latched, not-yet-selected alarm events.
- fail  out  1  sticky; a message exhausted its retries.
- fail_code  out  2  code of the most recent failed message.
- fail_clr  in  1  clears `fail` and `fail_code`.
- buzzer  out  1  local sounder.

## Operation
- Edge detect:
  - `alarms_q` registers `alarms` every cycle.
  - Event on bit i when `alarms[i] & ~alarms_q[i]`; the event sets `pending[i]`.
  - A held level produces exactly one event.
- FSM states: IDLE, SEND, WAIT_ACK, HOLD.
- IDLE, when `pending` is nonzero:
  - Select the highest-priority bit (fire > intrusion > rain).
  - Clear that pending bit and load `msg_code`.
  - Snapshot `occupants_in` into `msg_occupants`, set retry = 0, go to SEND.
- SEND:
  - `msg_valid` = 1. `msg_code` and `msg_occupants` are held stable until `msg_valid & msg_ready`.
  - On that handshake, clear the timer and go to WAIT_ACK.
- WAIT_ACK:
  - `msg_ack` → HOLD.
  - Otherwise, when timer == ACK_TIMEOUT−1:
    - If retry < MAX_RETRY: retry++, go to SEND with the same code and snapshot.
    - Else: `fail` = 1, `fail_code` = `msg_code`, go to HOLD.
- HOLD:
  - `msg_code` = 0.
  - Count HOLDOFF_CYCLES cycles, then go to IDLE.
- `msg_ack` outside WAIT_ACK is ignored.
- No preemption: a fire event arriving mid-message waits in `pending`.
- A new event on the in-flight bit re-sets its pending bit and yields a second message later.
- `buzzer` (registered) = `alarms[2] | pending[2] | (in-flight code == 1)`.
- If `fail_clr` and a new failure occur in the same cycle, the failure wins.
- Widths:
  - timer: $clog2(ACK_TIMEOUT+1) bits.
  - retry: $clog2(MAX_RETRY+1) bits.
  - hold counter: $clog2(HOLDOFF_CYCLES+1) bits.
  - No counter wraps; each saturates at its terminal value.

## Timing
- Reset (`reset` = 0 at an edge):
  - All outputs 0, `alarms_q` = 0, all counters 0, state IDLE. This applies from any state.
  - After release, an alarm already high counts as an event.
- Latency:
  - An alarm rising and sampled at edge k sets `pending` after edge k.
  - `msg_valid` rises after edge k+1.
- Ack vs timeout in the same cycle: ack wins.
- Resend: `msg_valid` reasserts in the cycle after the timeout edge.
- Event on a bit in the same cycle it is selected: the bit is cleared by the selection, then set by the event; the bit ends up set.
- Back-to-back messages are separated by exactly HOLDOFF_CYCLES cycles of HOLD plus 1 cycle of IDLE.

## Structure
- `home_pkg` holds:
  - alarm bit index constants (FIRE = 2, INTRUSION = 1, RAIN = 0);
  - message code constants;
  - the FSM state enum.
- Sub-module `alarm_edge_latch`: edge detect plus pending set/clear with a select-clear port. The priority pick and FSM stay in `alarm_dispatcher`.

## Test plan
- Reset with `alarms` = 000: all outputs 0. After release, `msg_valid` stays 0 for 50 cycles.
- `alarms` = 111 in one cycle, `msg_ready` = 1, ack 3 cycles after each handshake:
  - `msg_code` sequence is 1, 2, 3;
  - messages are spaced by HOLDOFF+1 idle cycles;
  - `pending` steps 111 → 011 → 001 → 000.
- `msg_ready` low for 10 cycles while `occupants_in` changes 5 → 9: `msg_valid` held, `msg_code` and `msg_occupants` (5) stable.
- ACK_TIMEOUT = 8, MAX_RETRY = 2, intrusion event, no ack:
  - exactly 3 handshakes, 8 cycles apart plus resend;
  - then `fail` = 1, `fail_code` = 2;
  - `fail_clr` pulse clears both.
- `alarms[0]` held high 100 cycles: exactly one rain message. Drop and re-raise: a second message.
- `reset` low during WAIT_ACK with `pending` = 100: all outputs 0 the next cycle, and no message follows until a new event.

Source files
------------

// File: rtl/home_pkg.sv
// Shared constants for the home alarm path: alarm bit positions, panel
// message codes and the dispatcher FSM state encoding.
package home_pkg;

  localparam int FIRE      = 2;
  localparam int INTRUSION = 1;
  localparam int RAIN      = 0;

  localparam logic [1:0] CODE_NONE      = 2'd0;
  localparam logic [1:0] CODE_FIRE      = 2'd1;
  localparam logic [1:0] CODE_INTRUSION = 2'd2;
  localparam logic [1:0] CODE_RAIN      = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SEND     = 2'd1,
    ST_WAIT_ACK = 2'd2,
    ST_HOLD     = 2'd3
  } state_t;

endpackage

// File: rtl/alarm_edge_latch.sv
// Rising-edge detector on the alarm levels feeding a pending-event latch.
// A selection clear and a new event in the same cycle leave the bit set.
module alarm_edge_latch (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] alarms,
  input  logic [2:0] sel_clr,
  output logic [2:0] pending
);

  logic [2:0] alarms_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      alarms_q <= '0;
      pending  <= '0;
    end else begin
      alarms_q <= alarms;
      pending  <= (pending & ~sel_clr) | (alarms & ~alarms_q);
    end
  end

endmodule

// File: rtl/alarm_dispatcher.sv
// Turns alarm events into prioritised panel messages with ack timeout,
// bounded resends, a post-message holdoff, sticky failure report and buzzer.
//
//   state    | meaning
//   IDLE     | no message in flight; picks highest pending event
//   SEND     | message offered on msg_valid until msg_ready
//   WAIT_ACK | handshake done; waiting for msg_ack or timeout
//   HOLD     | enforced idle gap after a delivered or failed message
module alarm_dispatcher
  import home_pkg::*;
#(
  parameter int ACK_TIMEOUT    = 255,
  parameter int MAX_RETRY      = 3,
  parameter int HOLDOFF_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] alarms,
  input  logic [7:0] occupants_in,
  output logic       msg_valid,
  input  logic       msg_ready,
  output logic [1:0] msg_code,
  output logic [7:0] msg_occupants,
  input  logic       msg_ack,
  output logic [2:0] pending,
  output logic       fail,
  output logic [1:0] fail_code,
  input  logic       fail_clr,
  output logic       buzzer
);

  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int HW = $clog2(HOLDOFF_CYCLES + 1);

  localparam logic [TW-1:0] TIMER_TC  = TW'(ACK_TIMEOUT - 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);
  localparam logic [HW-1:0] HOLD_TC   = HW'(HOLDOFF_CYCLES - 1);

  state_t        state, state_nxt;
  logic [2:0]    sel_clr;
  logic [1:0]    sel_code;
  logic [1:0]    code_q;
  logic [TW-1:0] timer_q;
  logic [RW-1:0] retry_q;
  logic [HW-1:0] hold_q;
  logic          timeout;
  logic          fail_now;
  logic          in_flight;

  alarm_edge_latch u_latch (
    .clk     (clk),
    .reset   (reset),
    .alarms  (alarms),
    .sel_clr (sel_clr),
    .pending (pending)
  );

  always_ff @(posedge clk) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    sel_clr   = '0;
    sel_code  = CODE_NONE;
    timeout   = 1'b0;
    fail_now  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (|pending) begin
          state_nxt = ST_SEND;
          if (pending[FIRE]) begin
            sel_clr[FIRE] = 1'b1;
            sel_code      = CODE_FIRE;
          end else if (pending[INTRUSION]) begin
            sel_clr[INTRUSION] = 1'b1;
            sel_code           = CODE_INTRUSION;
          end else begin
            sel_clr[RAIN] = 1'b1;
            sel_code      = CODE_RAIN;
          end
        end
      end
      ST_SEND: begin
        if (msg_ready) state_nxt = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        // ack beats a coincident timeout
        if (msg_ack) begin
          state_nxt = ST_HOLD;
        end else if (timer_q == TIMER_TC) begin
          timeout = 1'b1;
          if (retry_q < RETRY_MAX) begin
            state_nxt = ST_SEND;
          end else begin
            fail_now  = 1'b1;
            state_nxt = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (hold_q == HOLD_TC) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    in_flight = (state == ST_SEND) || (state == ST_WAIT_ACK);
    msg_valid = (state == ST_SEND);
    msg_code  = in_flight ? code_q : CODE_NONE;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      code_q        <= CODE_NONE;
      msg_occupants <= '0;
      timer_q       <= '0;
      retry_q       <= '0;
      hold_q        <= '0;
      fail          <= 1'b0;
      fail_code     <= CODE_NONE;
      buzzer        <= 1'b0;
    end else begin
      if (state == ST_IDLE && |pending) begin
        code_q        <= sel_code;
        msg_occupants <= occupants_in;
        retry_q       <= '0;
      end else if (timeout && !fail_now) begin
        retry_q <= retry_q + 1'b1;
      end

      // timer is zero whenever not waiting, so each handshake starts it fresh
      if (state != ST_WAIT_ACK)    timer_q <= '0;
      else if (timer_q != TIMER_TC) timer_q <= timer_q + 1'b1;

      if (state != ST_HOLD)        hold_q <= '0;
      else if (hold_q != HOLD_TC)  hold_q <= hold_q + 1'b1;

      if (fail_now) begin
        fail      <= 1'b1;
        fail_code <= code_q;
      end else if (fail_clr) begin
        fail      <= 1'b0;
        fail_code <= CODE_NONE;
      end

      buzzer <= alarms[FIRE] | pending[FIRE] | (in_flight && code_q == CODE_FIRE);
    end
  end

endmodule
